mem_ctrl: RTL and testbench



---
 rtl/mem_ctrl_pkg.sv | 35 +++
 rtl/mem_ctrl_if.sv | 47 ++++
 rtl/mem_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_mem_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared constants, state encoding and small helpers for the byte-serial memory controller.
package mem_ctrl_pkg;

  localparam int XLEN = 32;

  // Stores inside this window are paced by the UART buffer-full flag.
  localparam logic [XLEN-1:0] IO_ADDR_LO = 32'h0003_0000;
  localparam logic [XLEN-1:0] IO_ADDR_HI = 32'h0003_0007;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_LOAD  = 2'd2,
    ST_STORE = 2'd3
  } state_e;

  // Access length codes from the LSB.
  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd2;

  // Index of the last byte of an access; unknown codes are treated as a word.
  function automatic logic [1:0] last_byte_idx(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 2'd0;
      LEN_HALF: return 2'd1;
      default:  return 2'd3;
    endcase
  endfunction

  function automatic logic is_io_addr(input logic [XLEN-1:0] addr);
    return (addr >= IO_ADDR_LO) && (addr <= IO_ADDR_HI);
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Core-side request/response signals and the 8-bit RAM port of the memory controller.
//
// Handshake: a request (fet_mem_enable / lsb_mem_enable) is taken at a clock edge
// where the controller is idle; its address, length and data are latched there and
// need not be held afterwards. Busy outputs report that a new request would not be
// taken. mem_inst_ready stays high until an edge with stall=0 consumes it;
// mem_lsb_ready is a single-cycle completion pulse.
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  logic            fet_mem_enable;
  logic [XLEN-1:0] fet_pc;
  logic            lsb_mem_enable;
  logic            lsb_mem_wr;
  logic [1:0]      lsb_mem_len;
  logic [XLEN-1:0] lsb_mem_addr;
  logic [XLEN-1:0] lsb_mem_data;
  logic [7:0]      mem_din;
  logic            io_buffer_full;

  logic            mem_fet_busy;
  logic            mem_inst_ready;
  logic [XLEN-1:0] mem_inst;
  logic            mem_lsb_busy;
  logic            mem_lsb_ready;
  logic [XLEN-1:0] mem_lsb_data;
  logic [XLEN-1:0] mem_a;
  logic [7:0]      mem_dout;
  logic            mem_wr;

  // Controller view.
  modport slave (
    input  fet_mem_enable, fet_pc, lsb_mem_enable, lsb_mem_wr, lsb_mem_len,
           lsb_mem_addr, lsb_mem_data, mem_din, io_buffer_full,
    output mem_fet_busy, mem_inst_ready, mem_inst, mem_lsb_busy, mem_lsb_ready,
           mem_lsb_data, mem_a, mem_dout, mem_wr
  );

  // Core / RAM view.
  modport master (
    output fet_mem_enable, fet_pc, lsb_mem_enable, lsb_mem_wr, lsb_mem_len,
           lsb_mem_addr, lsb_mem_data, mem_din, io_buffer_full,
    input  mem_fet_busy, mem_inst_ready, mem_inst, mem_lsb_busy, mem_lsb_ready,
           mem_lsb_data, mem_a, mem_dout, mem_wr
  );

endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetch and load/store requests onto
// one byte-wide RAM port, assembling instructions and load data little-endian.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       flush,
  input  logic       stall,
  mem_ctrl_if.slave  bus,
  output state_e     state_o
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] mem_a_q, mem_a_d;
  logic [7:0]      mem_dout_q, mem_dout_d;
  logic            mem_wr_q, mem_wr_d;
  logic [1:0]      iss_q, iss_d;      // index of the last read address issued
  logic [1:0]      cnt_q, cnt_d;      // byte index being captured / written
  logic [1:0]      last_q, last_d;    // index of the final byte of this access
  logic            primed_q, primed_d; // first read data is due from the next edge on
  logic [XLEN-1:0] buf_q, buf_d;      // shared fetch/load assembly register
  logic [XLEN-1:0] st_data_q, st_data_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic            inst_rdy_q, inst_rdy_d;
  logic [XLEN-1:0] lsb_data_q, lsb_data_d;
  logic            lsb_rdy_q, lsb_rdy_d;
  logic [1:0]      nxt_idx;

  // State register; rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      iss_q      <= '0;
      cnt_q      <= '0;
      last_q     <= '0;
      primed_q   <= 1'b0;
      buf_q      <= '0;
      st_data_q  <= '0;
      inst_q     <= '0;
      inst_rdy_q <= 1'b0;
      lsb_data_q <= '0;
      lsb_rdy_q  <= 1'b0;
    end else if (rdy) begin
      state_q    <= state_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      mem_wr_q   <= mem_wr_d;
      iss_q      <= iss_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      primed_q   <= primed_d;
      buf_q      <= buf_d;
      st_data_q  <= st_data_d;
      inst_q     <= inst_d;
      inst_rdy_q <= inst_rdy_d;
      lsb_data_q <= lsb_data_d;
      lsb_rdy_q  <= lsb_rdy_d;
    end
  end

  // Arbitration, read pipeline, store sequencing and completion handling.
  always_comb begin
    state_d    = state_q;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    mem_wr_d   = mem_wr_q;
    iss_d      = iss_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    primed_d   = primed_q;
    buf_d      = buf_q;
    st_data_d  = st_data_q;
    inst_d     = inst_q;
    inst_rdy_d = inst_rdy_q;
    lsb_data_d = lsb_data_q;
    lsb_rdy_d  = 1'b0;
    nxt_idx    = cnt_q + 2'd1;

    case (state_q)
      ST_IDLE: begin
        mem_wr_d = 1'b0;
        iss_d    = '0;
        cnt_d    = '0;
        primed_d = 1'b0;
        if (bus.lsb_mem_enable) begin
          mem_a_d   = bus.lsb_mem_addr;
          last_d    = last_byte_idx(bus.lsb_mem_len);
          st_data_d = bus.lsb_mem_data;
          buf_d     = '0;
          if (bus.lsb_mem_wr) begin
            state_d    = ST_STORE;
            mem_dout_d = bus.lsb_mem_data[7:0];
            mem_wr_d   = !(is_io_addr(bus.lsb_mem_addr) && bus.io_buffer_full);
          end else begin
            state_d = ST_LOAD;
          end
        end else if (bus.fet_mem_enable && !flush) begin
          // Length is unknown until byte0 arrives; assume 32-bit.
          state_d = ST_FETCH;
          mem_a_d = bus.fet_pc;
          last_d  = 2'd3;
          buf_d   = '0;
        end
      end

      ST_FETCH, ST_LOAD: begin
        if (flush) begin
          state_d    = ST_IDLE;
          inst_rdy_d = 1'b0;
          lsb_rdy_d  = 1'b0;
        end else if (inst_rdy_q) begin
          if (!stall) begin
            state_d    = ST_IDLE;
            inst_rdy_d = 1'b0;
          end
        end else begin
          if (iss_q < last_q) begin
            mem_a_d = mem_a_q + 32'd1;
            iss_d   = iss_q + 2'd1;
          end
          if (primed_q) begin
            buf_d[{cnt_q, 3'b000} +: 8] = bus.mem_din;
            if (cnt_q == last_q) begin
              if (state_q == ST_FETCH) begin
                inst_d     = buf_d;
                inst_rdy_d = 1'b1;
              end else begin
                lsb_data_d = buf_d;
                lsb_rdy_d  = 1'b1;
                state_d    = ST_IDLE;
              end
            end else begin
              cnt_d = nxt_idx;
              // Low bits other than 2'b11 mark a compressed instruction.
              if (state_q == ST_FETCH && cnt_q == 2'd0 && bus.mem_din[1:0] != 2'b11)
                last_d = 2'd1;
            end
          end else begin
            primed_d = 1'b1;
          end
        end
      end

      ST_STORE: begin
        if (mem_wr_q) begin
          if (cnt_q == last_q) begin
            state_d   = ST_IDLE;
            mem_wr_d  = 1'b0;
            lsb_rdy_d = 1'b1;
          end else begin
            cnt_d      = nxt_idx;
            mem_a_d    = mem_a_q + 32'd1;
            mem_dout_d = st_data_q[{nxt_idx, 3'b000} +: 8];
            mem_wr_d   = !(is_io_addr(mem_a_q + 32'd1) && bus.io_buffer_full);
          end
        end else begin
          // Byte held back by a full I/O buffer: retry the same byte.
          mem_wr_d = !(is_io_addr(mem_a_q) && bus.io_buffer_full);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.mem_fet_busy   = (state_q != ST_IDLE) || bus.lsb_mem_enable;
  assign bus.mem_lsb_busy   = (state_q != ST_IDLE);
  assign bus.mem_inst_ready = inst_rdy_q;
  assign bus.mem_inst       = inst_q;
  assign bus.mem_lsb_ready  = lsb_rdy_q;
  assign bus.mem_lsb_data   = lsb_data_q;
  assign bus.mem_a          = mem_a_q;
  assign bus.mem_dout       = mem_dout_q;
  assign bus.mem_wr         = mem_wr_q && rdy;
  assign state_o            = state_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model, table of single transactions, and
// hand-written sequences for arbitration, I/O back-pressure, flush, stall and rdy.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic   clk, rst, rdy, flush, stall;
  state_e dbg_state;
  mem_ctrl_if bus();

  mem_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .rdy     (rdy),
    .flush   (flush),
    .stall   (stall),
    .bus     (bus),
    .state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];   // expected I/O-window write bytes, in order

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // ---------------- RAM model ----------------
  logic [7:0] ram [1024];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 8'h00;
      ram[10'h000] <= 8'h13; ram[10'h001] <= 8'h05;
      ram[10'h002] <= 8'h10; ram[10'h003] <= 8'h00;
      ram[10'h004] <= 8'h01; ram[10'h005] <= 8'h45;
      ram[10'h100] <= 8'hEF; ram[10'h101] <= 8'hBE;
      ram[10'h102] <= 8'hAD; ram[10'h103] <= 8'hDE;
      bus.mem_din  <= 8'h00;
    end else begin
      bus.mem_din <= ram[bus.mem_a[9:0]];
      if (bus.mem_wr) begin
        if (bus.mem_a >= 32'h0003_0000) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL io_write_unexpected: got %h at %h expected none", bus.mem_dout, bus.mem_a);
          end else begin
            check("io_write_data", {24'h0, bus.mem_dout}, {24'h0, exp_q.pop_front()});
          end
        end else begin
          ram[bus.mem_a[9:0]] <= bus.mem_dout;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_lsb(input logic wr, input logic [1:0] len, input logic [31:0] addr, input logic [31:0] data);
    bus.lsb_mem_enable = 1'b1;
    bus.lsb_mem_wr     = wr;
    bus.lsb_mem_len    = len;
    bus.lsb_mem_addr   = addr;
    bus.lsb_mem_data   = data;
  endtask

  task automatic drive_fetch(input logic [31:0] pc);
    bus.fet_mem_enable = 1'b1;
    bus.fet_pc         = pc;
  endtask

  // Called at a negedge; counts edges until the chosen ready is seen.
  task automatic wait_ready(input string name, input logic want_fetch, output int lat,
                            output logic [31:0] got);
    bit ok;
    ok  = 1'b0;
    lat = 0;
    got = '0;
    while (!ok && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (want_fetch ? bus.mem_inst_ready : bus.mem_lsb_ready) begin
        ok  = 1'b1;
        got = want_fetch ? bus.mem_inst : bus.mem_lsb_data;
      end
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got no ready expected ready within 20 cycles", name);
    end
  endtask

  // One complete transaction from an idle controller.
  task automatic do_req(input string name, input logic is_fetch, input logic is_store,
                        input logic [1:0] len, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_data, input int exp_lat);
    int lat;
    logic [31:0] got;
    @(negedge clk);
    if (is_fetch) drive_fetch(addr);
    else          drive_lsb(is_store, len, addr, wdata);
    @(posedge clk);
    @(negedge clk);
    bus.fet_mem_enable = 1'b0;
    bus.lsb_mem_enable = 1'b0;
    if (is_fetch) check({name, "_fet_busy"}, {31'h0, bus.mem_fet_busy}, 32'h1);
    wait_ready(name, is_fetch, lat, got);
    check({name, "_lat"}, lat, exp_lat);
    if (!is_store) check({name, "_data"}, got, exp_data);
    if (is_fetch) begin
      @(posedge clk);
      @(negedge clk);
      check({name, "_fet_busy_end"}, {31'h0, bus.mem_fet_busy}, 32'h0);
    end
    check({name, "_idle"}, 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        is_fetch;
    logic        is_store;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int          lat;
    logic [31:0] got;
    int          seen;

    vecs[0]  = '{1'b1, 1'b0, 2'd0, 32'h0000_0000, 32'h0,          32'h0010_0513, 5};
    vecs[1]  = '{1'b1, 1'b0, 2'd0, 32'h0000_0004, 32'h0,          32'h0000_4501, 3};
    vecs[2]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0100, 32'h0,          32'hDEAD_BEEF, 5};
    vecs[3]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0101, 32'h0,          32'h0000_00BE, 2};
    vecs[4]  = '{1'b0, 1'b0, 2'd1, 32'h0000_0102, 32'h0,          32'h0000_DEAD, 3};
    vecs[5]  = '{1'b1, 1'b0, 2'd0, 32'h0000_0102, 32'h0,          32'h0000_DEAD, 3};
    vecs[6]  = '{1'b0, 1'b1, 2'd2, 32'h0000_0200, 32'h1122_3344,  32'h0,         4};
    vecs[7]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0200, 32'h0,          32'h1122_3344, 5};
    vecs[8]  = '{1'b0, 1'b1, 2'd1, 32'h0000_0204, 32'h0000_A5B6,  32'h0,         2};
    vecs[9]  = '{1'b0, 1'b1, 2'd0, 32'h0000_0206, 32'h0000_007F,  32'h0,         1};
    vecs[10] = '{1'b0, 1'b0, 2'd2, 32'h0000_0204, 32'h0,          32'h007F_A5B6, 5};
    vecs[11] = '{1'b1, 1'b0, 2'd0, 32'h0000_0204, 32'h0,          32'h0000_A5B6, 3};
    vecs[12] = '{1'b1, 1'b0, 2'd0, 32'h0000_0206, 32'h0,          32'h0000_007F, 5};
    vecs[13] = '{1'b0, 1'b0, 2'd1, 32'h0000_01FF, 32'h0,          32'h0000_4400, 3};

    rst = 1'b1; rdy = 1'b1; flush = 1'b0; stall = 1'b0;
    bus.fet_mem_enable = 1'b0; bus.fet_pc = '0;
    bus.lsb_mem_enable = 1'b0; bus.lsb_mem_wr = 1'b0; bus.lsb_mem_len = '0;
    bus.lsb_mem_addr = '0; bus.lsb_mem_data = '0; bus.io_buffer_full = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state",     32'(dbg_state), 32'(ST_IDLE));
    check("rst_mem_a",     bus.mem_a, 32'h0);
    check("rst_mem_wr",    {31'h0, bus.mem_wr}, 32'h0);
    check("rst_inst_rdy",  {31'h0, bus.mem_inst_ready}, 32'h0);
    check("rst_lsb_rdy",   {31'h0, bus.mem_lsb_ready}, 32'h0);
    check("rst_fet_busy",  {31'h0, bus.mem_fet_busy}, 32'h0);
    check("rst_inst",      bus.mem_inst, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Table of single transactions.
    for (int i = 0; i < 14; i++)
      do_req($sformatf("vec%0d", i), vecs[i].is_fetch, vecs[i].is_store, vecs[i].len,
             vecs[i].addr, vecs[i].wdata, vecs[i].exp_data, vecs[i].exp_lat);

    // Load and fetch requested together: load wins, fetch follows after one idle cycle.
    @(negedge clk);
    drive_lsb(1'b0, 2'd2, 32'h0000_0100, 32'h0);
    drive_fetch(32'h0000_0000);
    @(posedge clk);
    @(negedge clk);
    check("arb_state_load", 32'(dbg_state), 32'(ST_LOAD));
    wait_ready("arb_load", 1'b0, lat, got);
    bus.lsb_mem_enable = 1'b0;
    check("arb_load_lat",  lat, 32'd5);
    check("arb_load_data", got, 32'hDEAD_BEEF);
    @(posedge clk);
    @(negedge clk);
    check("arb_lsb_pulse", {31'h0, bus.mem_lsb_ready}, 32'h0);
    check("arb_state_fetch", 32'(dbg_state), 32'(ST_FETCH));
    bus.fet_mem_enable = 1'b0;
    wait_ready("arb_fetch", 1'b1, lat, got);
    check("arb_fetch_lat",  lat, 32'd5);
    check("arb_fetch_data", got, 32'h0010_0513);
    @(posedge clk);
    @(negedge clk);

    // Byte store into the I/O window held off by io_buffer_full for three edges.
    exp_q.push_back(8'h41);
    @(negedge clk);
    bus.io_buffer_full = 1'b1;
    drive_lsb(1'b1, 2'd0, 32'h0003_0000, 32'h0000_0041);
    @(posedge clk);
    @(negedge clk);
    bus.lsb_mem_enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("io_hold%0d_wr", k), {31'h0, bus.mem_wr}, 32'h0);
      if (k == 2) bus.io_buffer_full = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    check("io_wr",      {31'h0, bus.mem_wr}, 32'h1);
    check("io_dout",    {24'h0, bus.mem_dout}, 32'h41);
    check("io_addr",    bus.mem_a, 32'h0003_0000);
    check("io_rdy_early", {31'h0, bus.mem_lsb_ready}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("io_rdy",     {31'h0, bus.mem_lsb_ready}, 32'h1);
    check("io_wr_done", {31'h0, bus.mem_wr}, 32'h0);
    check("io_idle",    32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    check("io_q_empty", exp_q.size(), 32'd0);

    // Flush two cycles into a 32-bit fetch.
    drive_fetch(32'h0000_0000);
    @(posedge clk);
    @(negedge clk);
    bus.fet_mem_enable = 1'b0;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle",     32'(dbg_state), 32'(ST_IDLE));
    check("flush_fet_busy", {31'h0, bus.mem_fet_busy}, 32'h0);
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.mem_inst_ready) seen++;
      @(posedge clk);
      @(negedge clk);
    end
    check("flush_no_ready", seen, 32'd0);

    // Flush at the same edge as a fetch request: request ignored.
    drive_fetch(32'h0000_0004);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.fet_mem_enable = 1'b0;
    flush = 1'b0;
    check("flush_req_ignored", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);

    // Stall held across completion of a 16-bit fetch.
    stall = 1'b1;
    drive_fetch(32'h0000_0004);
    @(posedge clk);
    @(negedge clk);
    bus.fet_mem_enable = 1'b0;
    wait_ready("stall_fetch", 1'b1, lat, got);
    check("stall_lat",  lat, 32'd3);
    check("stall_data", got, 32'h0000_4501);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("stall_hold%0d_rdy", k), {31'h0, bus.mem_inst_ready}, 32'h1);
      check($sformatf("stall_hold%0d_inst", k), bus.mem_inst, 32'h0000_4501);
    end
    stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("stall_release_rdy", {31'h0, bus.mem_inst_ready}, 32'h0);
    check("stall_release_idle", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);

    // rdy low freezes a store and masks the write strobe.
    drive_lsb(1'b1, 2'd0, 32'h0000_0300, 32'h0000_005A);
    @(posedge clk);
    @(negedge clk);
    bus.lsb_mem_enable = 1'b0;
    check("rdy_wr_before", {31'h0, bus.mem_wr}, 32'h1);
    rdy = 1'b0;
    #1;
    check("rdy_wr_masked", {31'h0, bus.mem_wr}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("rdy_frozen_state", 32'(dbg_state), 32'(ST_STORE));
    check("rdy_frozen_rdy", {31'h0, bus.mem_lsb_ready}, 32'h0);
    rdy = 1'b1;
    #1;
    check("rdy_wr_after", {31'h0, bus.mem_wr}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    check("rdy_store_done", {31'h0, bus.mem_lsb_ready}, 32'h1);
    do_req("rdy_readback", 1'b0, 1'b0, 2'd0, 32'h0000_0300, 32'h0, 32'h0000_005A, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
